// File: rtl/flash_rd_ctrl_pkg.sv
// Shared state encoding and default timing for the parallel NOR flash read sequencer.
// The defaults are also picked up by the SDRAM and boot loader blocks.
package flash_rd_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_RST_HOLD  = 3'd0,
    ST_RST_RECOV = 3'd1,
    ST_IDLE      = 3'd2,
    ST_AVD       = 3'd3,
    ST_ACCESS    = 3'd4,
    ST_TURN      = 3'd5
  } state_t;

  // Cycle counts at 25 MHz; 3 x 40 ns of output-enable covers the 100 ns tACC.
  localparam int DEF_RST_HOLD_CYCLES  = 13;
  localparam int DEF_RST_RECOV_CYCLES = 2;
  localparam int DEF_AVD_CYCLES       = 1;
  localparam int DEF_ACCESS_CYCLES    = 3;
  localparam int DEF_TURN_CYCLES      = 1;
  localparam int DEF_CNT_W            = 5;

  localparam logic [15:0] DATA_RESET = 16'h0000;
  localparam logic [23:0] ADDR_RESET = 24'h00_0000;

endpackage

// File: rtl/flash_rd_ctrl.sv
// Read-only sequencer for a 16-bit AVD-latched NOR flash: power-on reset pulse, then
// single-word async reads for one client. Every output comes straight from a register.
module flash_rd_ctrl
  import flash_rd_ctrl_pkg::*;
#(
  parameter int RST_HOLD_CYCLES  = DEF_RST_HOLD_CYCLES,
  parameter int RST_RECOV_CYCLES = DEF_RST_RECOV_CYCLES,
  parameter int AVD_CYCLES       = DEF_AVD_CYCLES,
  parameter int ACCESS_CYCLES    = DEF_ACCESS_CYCLES,
  parameter int TURN_CYCLES      = DEF_TURN_CYCLES,
  parameter int CNT_W            = DEF_CNT_W
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic [23:0] i_req_addr,
  output logic        o_rsp_valid,
  output logic [15:0] o_rsp_data,
  output logic        o_busy,
  output logic        o_flash_dclk,
  output logic        o_flash_nreset,
  output logic        o_flash_nce,
  output logic        o_flash_noe,
  output logic        o_flash_navd,
  output logic        o_flash_nwe,
  output logic [23:0] o_flash_padd,
  input  logic [15:0] i_flash_data
);

  localparam logic [CNT_W-1:0] HOLD_LD   = CNT_W'(RST_HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] RECOV_LD  = CNT_W'(RST_RECOV_CYCLES - 1);
  localparam logic [CNT_W-1:0] AVD_LD    = CNT_W'(AVD_CYCLES - 1);
  localparam logic [CNT_W-1:0] ACCESS_LD = CNT_W'(ACCESS_CYCLES - 1);
  localparam logic [CNT_W-1:0] TURN_LD   = CNT_W'(TURN_CYCLES - 1);

  state_t            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_req_ready;
  logic              r_rsp_valid;
  logic [15:0]       r_rsp_data;
  logic              r_busy;
  logic              r_nreset;
  logic              r_nce;
  logic              r_noe;
  logic              r_navd;
  logic [23:0]       r_padd;
  logic              w_cnt_zero;

  assign w_cnt_zero = (r_cnt == '0);

  // The counter comes out of reset preloaded so the first hold phase is full length.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= ST_RST_HOLD;
      r_cnt       <= HOLD_LD;
      r_req_ready <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= DATA_RESET;
      r_busy      <= 1'b1;
      r_nreset    <= 1'b0;
      r_nce       <= 1'b1;
      r_noe       <= 1'b1;
      r_navd      <= 1'b1;
      r_padd      <= ADDR_RESET;
    end else begin
      r_rsp_valid <= 1'b0;
      case (r_state)
        ST_RST_HOLD: begin
          if (w_cnt_zero) begin
            r_state  <= ST_RST_RECOV;
            r_cnt    <= RECOV_LD;
            r_nreset <= 1'b1;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        ST_RST_RECOV: begin
          if (w_cnt_zero) begin
            r_state     <= ST_IDLE;
            r_req_ready <= 1'b1;
            r_busy      <= 1'b0;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        ST_IDLE: begin
          if (i_req_valid && r_req_ready) begin
            r_state     <= ST_AVD;
            r_cnt       <= AVD_LD;
            r_padd      <= i_req_addr;
            r_nce       <= 1'b0;
            r_navd      <= 1'b0;
            r_req_ready <= 1'b0;
            r_busy      <= 1'b1;
          end
        end
        ST_AVD: begin
          if (w_cnt_zero) begin
            r_state <= ST_ACCESS;
            r_cnt   <= ACCESS_LD;
            r_navd  <= 1'b1;
            r_noe   <= 1'b0;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        ST_ACCESS: begin
          // Capture on the edge that ends the last output-enable cycle.
          if (w_cnt_zero) begin
            r_state     <= ST_TURN;
            r_cnt       <= TURN_LD;
            r_rsp_data  <= i_flash_data;
            r_rsp_valid <= 1'b1;
            r_nce       <= 1'b1;
            r_noe       <= 1'b1;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        ST_TURN: begin
          if (w_cnt_zero) begin
            r_state     <= ST_IDLE;
            r_req_ready <= 1'b1;
            r_busy      <= 1'b0;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        default: begin
          r_state     <= ST_RST_HOLD;
          r_cnt       <= HOLD_LD;
          r_req_ready <= 1'b0;
          r_busy      <= 1'b1;
          r_nreset    <= 1'b0;
          r_nce       <= 1'b1;
          r_noe       <= 1'b1;
          r_navd      <= 1'b1;
        end
      endcase
    end
  end

  assign o_req_ready    = r_req_ready;
  assign o_rsp_valid    = r_rsp_valid;
  assign o_rsp_data     = r_rsp_data;
  assign o_busy         = r_busy;
  assign o_flash_dclk   = 1'b0;
  assign o_flash_nreset = r_nreset;
  assign o_flash_nce    = r_nce;
  assign o_flash_noe    = r_noe;
  assign o_flash_navd   = r_navd;
  assign o_flash_nwe    = 1'b1;
  assign o_flash_padd   = r_padd;

endmodule

// File: tb/tb_flash_rd_ctrl.sv
// Directed bench for flash_rd_ctrl: a 100 ns tACC flash model, a table of reads and
// hand-written sequences for reset, back-to-back, mid-access reset and a retimed instance.
module tb_flash_rd_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        req_valid = 1'b0;
  logic [23:0] req_addr = '0;
  logic        req2_valid = 1'b0;
  logic [23:0] req2_addr = '0;

  logic        w_ready, w_rsp_valid, w_busy, w_dclk, w_nreset, w_nce, w_noe, w_navd, w_nwe;
  logic [15:0] w_rsp_data, w_fdata;
  logic [23:0] w_padd;
  logic        w2_ready, w2_rsp_valid, w2_busy, w2_dclk, w2_nreset, w2_nce, w2_noe, w2_navd, w2_nwe;
  logic [15:0] w2_rsp_data, w2_fdata;
  logic [23:0] w2_padd;

  int total = 0;
  int bad = 0;

  always #20 clk = ~clk;

  flash_rd_ctrl u_dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_req_valid(req_valid), .o_req_ready(w_ready),
    .i_req_addr(req_addr), .o_rsp_valid(w_rsp_valid), .o_rsp_data(w_rsp_data), .o_busy(w_busy),
    .o_flash_dclk(w_dclk), .o_flash_nreset(w_nreset), .o_flash_nce(w_nce), .o_flash_noe(w_noe),
    .o_flash_navd(w_navd), .o_flash_nwe(w_nwe), .o_flash_padd(w_padd), .i_flash_data(w_fdata)
  );

  flash_rd_ctrl #(.AVD_CYCLES(2), .ACCESS_CYCLES(1), .TURN_CYCLES(3)) u_dut_ovr (
    .i_clk(clk), .i_rst_n(rst_n), .i_req_valid(req2_valid), .o_req_ready(w2_ready),
    .i_req_addr(req2_addr), .o_rsp_valid(w2_rsp_valid), .o_rsp_data(w2_rsp_data), .o_busy(w2_busy),
    .o_flash_dclk(w2_dclk), .o_flash_nreset(w2_nreset), .o_flash_nce(w2_nce), .o_flash_noe(w2_noe),
    .o_flash_navd(w2_navd), .o_flash_nwe(w2_nwe), .o_flash_padd(w2_padd), .i_flash_data(w2_fdata)
  );

  // Flash model: data becomes valid only 100 time units after noe falls; earlier it reads 0BAD.
  time         t_oe_fall = 0;
  int          tacc_viol = 0;
  logic [15:0] fl_data = 16'h0BAD;
  assign w_fdata  = fl_data;
  assign w2_fdata = w2_padd[15:0] ^ 16'hA5A5;

  always @(negedge w_noe) t_oe_fall = $time;
  always @(negedge clk) begin
    if (w_noe === 1'b0 && w_nce === 1'b0 && ($time - t_oe_fall) >= 100)
      fl_data = w_padd[15:0] ^ 16'hA5A5;
    else
      fl_data = 16'h0BAD;
  end
  always @(posedge w_noe) begin
    if (rst_n === 1'b1 && ($time - t_oe_fall) < 100) tacc_viol++;
  end

  typedef struct {
    logic [23:0] addr;
    logic [15:0] exp_data;
    logic        scramble;
  } vec_t;
  vec_t vecs[6];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Called at the sample point right after rst_n rises.
  task automatic run_reset_seq(input string tag);
    int   lo = 0;
    int   hi = 0;
    int   n = 0;
    logic act = 1'b0;
    logic busy_bad = 1'b0;
    logic rsp_seen = 1'b0;
    while (w_ready !== 1'b1 && n < 40) begin
      if (w_nreset === 1'b0) lo++; else hi++;
      if (w_nce !== 1'b1 || w_noe !== 1'b1 || w_navd !== 1'b1) act = 1'b1;
      if (w_busy !== 1'b1) busy_bad = 1'b1;
      if (w_rsp_valid === 1'b1) rsp_seen = 1'b1;
      tick();
      n++;
    end
    $display("%s: nreset low %0d cycles, high %0d cycles, ready after %0d", tag, lo, hi, n);
    check({tag, "_nreset_low"}, lo, 13);
    check({tag, "_recov"}, hi, 2);
    check({tag, "_ready_cycle"}, n, 15);
    check({tag, "_no_activity"}, {31'd0, act}, 0);
    check({tag, "_busy_high"}, {31'd0, busy_bad}, 0);
    check({tag, "_no_rsp"}, {31'd0, rsp_seen}, 0);
    check({tag, "_busy_fall"}, {31'd0, w_busy}, 0);
  endtask

  task automatic do_read(input logic [23:0] addr, input logic [15:0] exp, input logic scr,
                         input string tag);
    int          k = 1;
    int          rsp_at = -1;
    int          rdy_at = -1;
    int          nav = 0;
    int          noe_lo = 0;
    int          rsp_cnt = 0;
    logic        padd_ok = 1'b1;
    logic [15:0] data = '0;
    req_valid = 1'b1;
    req_addr  = addr;
    tick();
    req_valid = 1'b0;
    while (k <= 20) begin
      if (w_navd === 1'b0) nav++;
      if (w_noe === 1'b0) noe_lo++;
      if (w_padd !== addr) padd_ok = 1'b0;
      if (w_rsp_valid === 1'b1) begin
        rsp_cnt++;
        if (rsp_at < 0) begin
          rsp_at = k;
          data = w_rsp_data;
        end
      end
      if (w_ready === 1'b1) begin
        rdy_at = k;
        break;
      end
      if (scr) begin
        req_valid = 1'($urandom_range(0, 1));
        req_addr  = 24'($urandom);
      end
      tick();
      k++;
    end
    req_valid = 1'b0;
    $display("%s: addr=%06h data=%04h rsp@C%0d ready@C%0d", tag, addr, data, rsp_at, rdy_at);
    check({tag, "_data"}, {16'd0, data}, {16'd0, exp});
    check({tag, "_rsp_at"}, rsp_at, 5);
    check({tag, "_ready_at"}, rdy_at, 6);
    check({tag, "_navd_cycles"}, nav, 1);
    check({tag, "_noe_cycles"}, noe_lo, 3);
    check({tag, "_rsp_pulses"}, rsp_cnt, 1);
    check({tag, "_padd_stable"}, {31'd0, padd_ok}, 1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int   cyc;
    int   nx;
    int   nr;
    int   xt[4];
    logic gap_ok;
    int   k;
    int   rsp_at;
    int   rdy_at;
    int   nav;
    int   noe_lo;
    logic [15:0] d2;

    vecs[0] = '{24'h00_1234, 16'hB791, 1'b0};
    vecs[1] = '{24'h00_0000, 16'hA5A5, 1'b0};
    vecs[2] = '{24'hFF_FFFF, 16'h5A5A, 1'b0};
    vecs[3] = '{24'hAB_CDEF, 16'h684A, 1'b0};
    vecs[4] = '{24'h5A_5A5A, 16'hFFFF, 1'b1};
    vecs[5] = '{24'h13_579B, 16'hF23E, 1'b1};

    // Reset state
    #5 rst_n = 1'b0;
    repeat (3) tick();
    check("rst_nreset", {31'd0, w_nreset}, 0);
    check("rst_nce", {31'd0, w_nce}, 1);
    check("rst_noe", {31'd0, w_noe}, 1);
    check("rst_navd", {31'd0, w_navd}, 1);
    check("rst_nwe", {31'd0, w_nwe}, 1);
    check("rst_dclk", {31'd0, w_dclk}, 0);
    check("rst_padd", {8'd0, w_padd}, 0);
    check("rst_ready", {31'd0, w_ready}, 0);
    check("rst_rsp_valid", {31'd0, w_rsp_valid}, 0);
    check("rst_rsp_data", {16'd0, w_rsp_data}, 0);
    check("rst_busy", {31'd0, w_busy}, 1);
    rst_n = 1'b1;
    run_reset_seq("reset1");

    // Table of single reads; the scramble rows wiggle req_* while busy
    for (int i = 0; i < 6; i++) begin
      do_read(vecs[i].addr, vecs[i].exp_data, vecs[i].scramble, $sformatf("read%0d", i));
      check($sformatf("read%0d_padd_hold", i), {8'd0, w_padd}, {8'd0, vecs[i].addr});
    end

    // Back-to-back reads with req_valid held high
    cyc = 0; nx = 0; nr = 0; gap_ok = 1'b1;
    req_valid = 1'b1;
    req_addr  = 24'd0;
    while (cyc < 60 && nr < 4) begin
      logic fire;
      if (w_rsp_valid === 1'b1) begin
        $display("b2b rsp %0d: data=%04h at cycle %0d", nr, w_rsp_data, cyc);
        check($sformatf("b2b_rsp%0d", nr), {16'd0, w_rsp_data}, {16'd0, 16'(nr) ^ 16'hA5A5});
        nr++;
      end
      fire = (w_ready === 1'b1) && req_valid && (nx < 4);
      if (fire) begin
        if (nx > 0 && w_nce !== 1'b1) gap_ok = 1'b0;
        xt[nx] = cyc;
        nx++;
      end
      tick();
      cyc++;
      if (fire) begin
        if (nx == 4) req_valid = 1'b0;
        else req_addr = 24'(nx);
      end
    end
    req_valid = 1'b0;
    check("b2b_transfers", nx, 4);
    check("b2b_rsps", nr, 4);
    check("b2b_nce_gap", {31'd0, gap_ok}, 1);
    for (int i = 1; i < 4; i++)
      if (i < nx) check($sformatf("b2b_spacing%0d", i), xt[i] - xt[i-1], 6);
    k = 0;
    while (w_ready !== 1'b1 && k < 20) begin
      tick();
      k++;
    end
    check("b2b_idle_again", {31'd0, w_ready}, 1);

    // Reset asserted in the second ACCESS cycle
    req_valid = 1'b1;
    req_addr  = 24'h00_BEEF;
    tick();
    req_valid = 1'b0;
    tick();
    tick();
    check("midrst_in_access", {31'd0, w_noe}, 0);
    rst_n = 1'b0;
    #1;
    $display("midrst: reset asserted during access of 00BEEF");
    check("midrst_nce", {31'd0, w_nce}, 1);
    check("midrst_noe", {31'd0, w_noe}, 1);
    check("midrst_navd", {31'd0, w_navd}, 1);
    check("midrst_nreset", {31'd0, w_nreset}, 0);
    check("midrst_busy", {31'd0, w_busy}, 1);
    nr = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (w_rsp_valid === 1'b1) nr++;
    end
    check("midrst_no_rsp", nr, 0);
    rst_n = 1'b1;
    run_reset_seq("reset2");
    do_read(24'h00_BEEF, 16'h1B4A, 1'b0, "post_rst_read");

    // Retimed instance: AVD=2, ACCESS=1, TURN=3
    k = 0;
    while (w2_ready !== 1'b1 && k < 40) begin
      tick();
      k++;
    end
    check("ovr_ready", {31'd0, w2_ready}, 1);
    req2_valid = 1'b1;
    req2_addr  = 24'h12_3456;
    tick();
    req2_valid = 1'b0;
    k = 1; rsp_at = -1; rdy_at = -1; nav = 0; noe_lo = 0; d2 = '0;
    while (k <= 20) begin
      if (w2_navd === 1'b0) nav++;
      if (w2_noe === 1'b0) noe_lo++;
      if (w2_rsp_valid === 1'b1 && rsp_at < 0) begin
        rsp_at = k;
        d2 = w2_rsp_data;
      end
      if (w2_ready === 1'b1) begin
        rdy_at = k;
        break;
      end
      tick();
      k++;
    end
    $display("ovr read: addr=123456 data=%04h rsp@C%0d ready@C%0d", d2, rsp_at, rdy_at);
    check("ovr_data", {16'd0, d2}, {16'd0, 16'h91F3});
    check("ovr_rsp_at", rsp_at, 4);
    check("ovr_ready_at", rdy_at, 7);
    check("ovr_navd_cycles", nav, 2);
    check("ovr_noe_cycles", noe_lo, 1);

    check("flash_tacc_violations", tacc_viol, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
